// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, operand sizes, flag
// positions, FSM states and width-dependent helpers.
package ex_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h09;
    localparam logic [7:0] OP_AND  = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h29;
    localparam logic [7:0] OP_XOR  = 8'h31;
    localparam logic [7:0] OP_CMP  = 8'h39;
    localparam logic [7:0] OP_MOV  = 8'h89;
    localparam logic [7:0] OP_IMUL = 8'hAF;
    localparam logic [7:0] OP_SHL  = 8'hE0;
    localparam logic [7:0] OP_SHR  = 8'hE8;

    localparam logic [1:0] SZ_8  = 2'b00;
    localparam logic [1:0] SZ_16 = 2'b01;
    localparam logic [1:0] SZ_32 = 2'b10;
    localparam logic [1:0] SZ_64 = 2'b11;

    localparam int unsigned FLAG_CF = 0;
    localparam int unsigned FLAG_ZF = 1;
    localparam int unsigned FLAG_SF = 2;
    localparam int unsigned FLAG_OF = 3;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_8:    return 64'h0000_0000_0000_00FF;
            SZ_16:   return 64'h0000_0000_0000_FFFF;
            SZ_32:   return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [6:0] size_bits(input logic [1:0] size);
        case (size)
            SZ_8:    return 7'd8;
            SZ_16:   return 7'd16;
            SZ_32:   return 7'd32;
            default: return 7'd64;
        endcase
    endfunction

    function automatic logic sign_bit(input logic [63:0] v, input logic [1:0] size);
        case (size)
            SZ_8:    return v[7];
            SZ_16:   return v[15];
            SZ_32:   return v[31];
            default: return v[63];
        endcase
    endfunction

    // Bit n of a widened value: carry/borrow out of bit n-1.
    function automatic logic carry_bit(input logic [64:0] v, input logic [1:0] size);
        case (size)
            SZ_8:    return v[8];
            SZ_16:   return v[16];
            SZ_32:   return v[32];
            default: return v[64];
        endcase
    endfunction

    function automatic logic [63:0] merge_result(input logic [63:0] res,
                                                 input logic [63:0] oper1,
                                                 input logic [1:0]  size);
        case (size)
            SZ_8, SZ_16: return (oper1 & ~size_mask(size)) | (res & size_mask(size));
            SZ_32:       return {32'h0, res[31:0]};
            default:     return res;
        endcase
    endfunction

    function automatic logic [3:0] make_flags(input logic        of,
                                              input logic [63:0] res,
                                              input logic [1:0]  size,
                                              input logic        cf);
        logic [3:0] f;
        f          = '0;
        f[FLAG_OF] = of;
        f[FLAG_SF] = sign_bit(res, size);
        f[FLAG_ZF] = ((res & size_mask(size)) == '0);
        f[FLAG_CF] = cf;
        return f;
    endfunction

endpackage

// File: rtl/ex_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; done pulses
// for the single cycle in which the low n product bits are final.
module ex_mul
    import ex_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_size,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_product
);

    logic        r_busy;
    logic [6:0]  r_cnt;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= size_bits(i_size);
            r_a    <= i_a & size_mask(i_size);
            r_b    <= i_b & size_mask(i_size);
            r_acc  <= '0;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt - 7'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == '0);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/flags/merge for single-cycle ops, iterative
// IMUL, and a single-entry output register toward writeback.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_nop,
    input  logic [7:0]   in_oper,
    input  logic [W-1:0] in_oper1,
    input  logic [W-1:0] in_oper2,
    input  logic [3:0]   in_dstreg,
    input  logic [1:0]   in_size,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_dstreg,
    output logic [W-1:0] out_result,
    output logic         out_we,
    output logic [3:0]   out_flags,
    output logic         out_flags_we
);

    state_t       r_state;
    logic         r_out_valid;
    logic         r_out_we;
    logic         r_out_flags_we;
    logic [3:0]   r_out_dstreg;
    logic [3:0]   r_out_flags;
    logic [W-1:0] r_out_result;
    logic [W-1:0] r_mul_oper1;
    logic [3:0]   r_mul_dstreg;
    logic [1:0]   r_mul_size;

    logic         w_accept;
    logic         w_mul_start;
    logic         w_mul_busy;
    logic         w_mul_done;
    logic         w_mul_fire;
    logic [W-1:0] w_mul_product;
    logic [W-1:0] w_mul_result;
    logic [3:0]   w_mul_flags;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W:0]   w_shl;
    logic [W:0]   w_shr;
    logic [5:0]   w_cnt;
    logic [W-1:0] w_res;
    logic [W-1:0] w_result;
    logic [3:0]   w_flags;
    logic         w_cf;
    logic         w_of;
    logic         w_we;
    logic         w_flags_we;
    logic         w_is_imul;
    logic         w_pass;
    logic         w_unknown;

    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && !in_nop && w_is_imul;
    assign w_mul_fire  = (r_state == ST_MUL) && w_mul_busy && w_mul_done;

    assign w_a    = in_oper1 & size_mask(in_size);
    assign w_b    = in_oper2 & size_mask(in_size);
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    assign w_cnt  = (in_size == SZ_64) ? in_oper2[5:0] : {1'b0, in_oper2[4:0]};
    // One guard bit past the field captures the last bit shifted out.
    assign w_shl  = {1'b0, w_a} << w_cnt;
    assign w_shr  = {w_a, 1'b0} >> w_cnt;

    always_comb begin
        w_res      = '0;
        w_cf       = 1'b0;
        w_of       = 1'b0;
        w_we       = 1'b1;
        w_flags_we = 1'b1;
        w_is_imul  = 1'b0;
        w_pass     = 1'b0;
        w_unknown  = 1'b0;
        case (in_oper)
            OP_ADD: begin
                w_res = w_sum[W-1:0];
                w_cf  = carry_bit(w_sum, in_size);
                w_of  = (sign_bit(w_a, in_size) == sign_bit(w_b, in_size)) &&
                        (sign_bit(w_sum[W-1:0], in_size) != sign_bit(w_a, in_size));
            end
            OP_SUB, OP_CMP: begin
                w_res = w_diff[W-1:0];
                w_cf  = carry_bit(w_diff, in_size);
                w_of  = (sign_bit(w_a, in_size) != sign_bit(w_b, in_size)) &&
                        (sign_bit(w_diff[W-1:0], in_size) != sign_bit(w_a, in_size));
                w_we  = (in_oper != OP_CMP);
            end
            OP_OR:   w_res = w_a | w_b;
            OP_AND:  w_res = w_a & w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_MOV: begin
                w_res      = w_b;
                w_flags_we = 1'b0;
            end
            OP_IMUL: w_is_imul = 1'b1;
            OP_SHL: begin
                w_res      = w_shl[W-1:0];
                w_cf       = carry_bit(w_shl, in_size);
                w_pass     = (w_cnt == '0);
                w_flags_we = (w_cnt != '0);
            end
            OP_SHR: begin
                w_res      = w_shr[W:1];
                w_cf       = w_shr[0];
                w_pass     = (w_cnt == '0);
                w_flags_we = (w_cnt != '0);
            end
            default: begin
                w_unknown  = 1'b1;
                w_we       = 1'b0;
                w_flags_we = 1'b0;
            end
        endcase
    end

    assign w_flags  = w_unknown ? '0 : make_flags(w_of, w_res, in_size, w_cf);
    assign w_result = w_unknown ? '0 :
                      w_pass    ? in_oper1 : merge_result(w_res, in_oper1, in_size);

    assign w_mul_result = merge_result(w_mul_product, r_mul_oper1, r_mul_size);
    assign w_mul_flags  = make_flags(1'b0, w_mul_product, r_mul_size, 1'b0);

    ex_mul u_mul (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_start   (w_mul_start),
        .i_size    (in_size),
        .i_a       (in_oper1),
        .i_b       (in_oper2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // A flushed multiply keeps running in ex_mul; its done is ignored once
    // the FSM has left ST_MUL, and a new start simply reloads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_out_valid    <= 1'b0;
            r_out_we       <= 1'b0;
            r_out_flags_we <= 1'b0;
            r_out_dstreg   <= '0;
            r_out_flags    <= '0;
            r_out_result   <= '0;
            r_mul_oper1    <= '0;
            r_mul_dstreg   <= '0;
            r_mul_size     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !in_nop) begin
                        if (w_is_imul) begin
                            r_state      <= ST_MUL;
                            r_mul_oper1  <= in_oper1;
                            r_mul_dstreg <= in_dstreg;
                            r_mul_size   <= in_size;
                        end else begin
                            r_out_valid    <= 1'b1;
                            r_out_dstreg   <= in_dstreg;
                            r_out_result   <= w_result;
                            r_out_we       <= w_we;
                            r_out_flags    <= w_flags;
                            r_out_flags_we <= w_flags_we;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_fire) begin
                        r_state        <= ST_IDLE;
                        r_out_valid    <= 1'b1;
                        r_out_dstreg   <= r_mul_dstreg;
                        r_out_result   <= w_mul_result;
                        r_out_we       <= 1'b1;
                        r_out_flags    <= w_mul_flags;
                        r_out_flags_we <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_dstreg   = r_out_dstreg;
    assign out_result   = r_out_result;
    assign out_we       = r_out_we;
    assign out_flags    = r_out_flags;
    assign out_flags_we = r_out_flags_we;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: one task per scenario, each with
// hand-computed expected values.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_nop = 1'b0;
    logic [7:0]  in_oper = '0;
    logic [63:0] in_oper1 = '0;
    logic [63:0] in_oper2 = '0;
    logic [3:0]  in_dstreg = '0;
    logic [1:0]  in_size = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_dstreg;
    logic [63:0] out_result;
    logic        out_we;
    logic [3:0]  out_flags;
    logic        out_flags_we;

    int checks = 0;
    int failures = 0;

    ex_stage #(.W(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_nop       (in_nop),
        .in_oper      (in_oper),
        .in_oper1     (in_oper1),
        .in_oper2     (in_oper2),
        .in_dstreg    (in_dstreg),
        .in_size      (in_size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dstreg   (out_dstreg),
        .out_result   (out_result),
        .out_we       (out_we),
        .out_flags    (out_flags),
        .out_flags_we (out_flags_we)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] dst, input logic [1:0] sz);
        in_valid  = 1'b1;
        in_nop    = 1'b0;
        in_oper   = op;
        in_oper1  = a;
        in_oper2  = b;
        in_dstreg = dst;
        in_size   = sz;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        checks++; if (out_result !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", out_result); end
        checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", out_flags); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        drive(OP_ADD, 64'h1122_3344_5566_77FF, 64'h01, 4'd3, SZ_8);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%0h exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0h exp=1", out_valid); end
        checks++; if (out_result !== 64'h1122_3344_5566_7700) begin failures++; $display("FAIL add_result got=%h exp=1122334455667700", out_result); end
        checks++; if (out_flags !== 4'b0011) begin failures++; $display("FAIL add_flags got=%b exp=0011", out_flags); end
        checks++; if (out_we !== 1'b1 || out_flags_we !== 1'b1) begin failures++; $display("FAIL add_we got=%b%b exp=11", out_we, out_flags_we); end
        checks++; if (out_dstreg !== 4'd3) begin failures++; $display("FAIL add_dst got=%0d exp=3", out_dstreg); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_consumed got=%0h exp=0", out_valid); end
    endtask

    task automatic test_sub();
        drive(OP_SUB, 64'hFFFF_FFFF_0000_0000, 64'h1, 4'd6, SZ_32);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_result !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL sub_result got=%h exp=00000000ffffffff", out_result); end
        checks++; if (out_flags !== 4'b0101) begin failures++; $display("FAIL sub_flags got=%b exp=0101", out_flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_imul();
        int cyc;
        drive(OP_IMUL, 64'h00FF, 64'h0101, 4'd5, SZ_16);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL imul_stall cyc=%0d got=%0h exp=0", cyc, in_ready); end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 17) begin failures++; $display("FAIL imul_latency got=%0d exp=17", cyc); end
        checks++; if (out_result !== 64'h0000_0000_0000_FFFF) begin failures++; $display("FAIL imul_result got=%h exp=000000000000ffff", out_result); end
        checks++; if (out_flags !== 4'b0100) begin failures++; $display("FAIL imul_flags got=%b exp=0100", out_flags); end
        checks++; if (out_dstreg !== 4'd5 || out_we !== 1'b1) begin failures++; $display("FAIL imul_dst_we got=%0d/%0h exp=5/1", out_dstreg, out_we); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(OP_CMP, 64'h5, 64'h5, 4'd7, SZ_64);
        @(posedge clk); #1;
        drive(OP_MOV, 64'hAAAA, 64'hDEAD_BEEF_1234_5678, 4'd9, SZ_32);
        #1;
        checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_flags_we !== 1'b1) begin failures++; $display("FAIL cmp_ctl got=%b%b%b exp=101", out_valid, out_we, out_flags_we); end
        checks++; if (out_flags !== 4'b0010) begin failures++; $display("FAIL cmp_flags got=%b exp=0010", out_flags); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cmp_hold_ready i=%0d got=%0h exp=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_flags !== 4'b0010 || out_dstreg !== 4'd7) begin failures++; $display("FAIL cmp_hold i=%0d got=%b/%b/%0d exp=1/0010/7", i, out_valid, out_flags, out_dstreg); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0h exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 64'h0000_0000_1234_5678) begin failures++; $display("FAIL mov_result got=%b/%h exp=1/0000000012345678", out_valid, out_result); end
        checks++; if (out_we !== 1'b1 || out_flags_we !== 1'b0 || out_dstreg !== 4'd9) begin failures++; $display("FAIL mov_ctl got=%b%b/%0d exp=10/9", out_we, out_flags_we, out_dstreg); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mov_consumed got=%0h exp=0", out_valid); end
    endtask

    task automatic test_misc();
        drive(8'h00, 64'h1, 64'h2, 4'd4, SZ_64);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_result !== 64'h0 || out_we !== 1'b0 || out_flags_we !== 1'b0) begin failures++; $display("FAIL unknown_op got=%b/%h/%b%b exp=1/0/00", out_valid, out_result, out_we, out_flags_we); end
        drive(OP_ADD, 64'h7, 64'h8, 4'd2, SZ_64);
        in_nop = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL nop_ready got=%0h exp=1", in_ready); end
        @(posedge clk); #1;
        in_nop = 1'b0;
        drive(OP_XOR, 64'hFFFF_0000_0000_8001, 64'h8001, 4'd11, SZ_16);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nop_no_output got=%0h exp=0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_result !== 64'hFFFF_0000_0000_0000 || out_flags !== 4'b0010) begin failures++; $display("FAIL xor_merge got=%h/%b exp=ffff000000000000/0010", out_result, out_flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_shift();
        drive(OP_SHL, 64'h8000_0000_0000_0001, 64'h41, 4'd2, SZ_64);
        @(posedge clk); #1;
        drive(OP_SHL, 64'h8000_0000_0000_0001, 64'h40, 4'd2, SZ_64);
        checks++; if (out_result !== 64'h2 || out_flags !== 4'b0001 || out_flags_we !== 1'b1) begin failures++; $display("FAIL shl_result got=%h/%b/%b exp=2/0001/1", out_result, out_flags, out_flags_we); end
        @(posedge clk); #1;
        drive(OP_SHR, 64'hFFFF_FFFF_FFFF_FF81, 64'h1, 4'd8, SZ_8);
        checks++; if (out_result !== 64'h8000_0000_0000_0001 || out_flags_we !== 1'b0 || out_we !== 1'b1) begin failures++; $display("FAIL shl_count0 got=%h/%b%b exp=8000000000000001/10", out_result, out_we, out_flags_we); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_result !== 64'hFFFF_FFFF_FFFF_FF40 || out_flags !== 4'b0001 || out_dstreg !== 4'd8) begin failures++; $display("FAIL shr_result got=%h/%b/%0d exp=ffffffffffffff40/0001/8", out_result, out_flags, out_dstreg); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_reset();
        logic seen;
        drive(OP_IMUL, 64'h3, 64'h5, 4'd1, SZ_64);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_blocks_ready got=%0h exp=0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%b/%b exp=1/0", in_ready, out_valid); end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_discard got=%0h exp=0", seen); end

        drive(OP_IMUL, 64'h3, 64'h5, 4'd1, SZ_64);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_we !== 1'b0 || out_flags_we !== 1'b0) begin failures++; $display("FAIL rst_ctl got=%b%b%b exp=000", out_valid, out_we, out_flags_we); end
        checks++; if (out_result !== 64'h0 || out_dstreg !== 4'd0 || out_flags !== 4'h0) begin failures++; $display("FAIL rst_data got=%h/%0d/%b exp=0/0/0000", out_result, out_dstreg, out_flags); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_partial got=%0h exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_imul();
        test_back_to_back();
        test_misc();
        test_shift();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
